// File: rtl/voice_bus_pkg.sv
// Shared definitions for the voice chip bus writer.
// Contents:
//   VOICE_ADDR_W  - width of an allophone/register address (7)
//   voice_cmd_t   - one queued write command (address + D5 bit)
//   VOICE_CMD_W   - packed width of voice_cmd_t
//   wr_state_e    - write-cycle FSM states
//   max_int       - helper used to size counters from the timing parameters
package voice_bus_pkg;

   localparam int VOICE_ADDR_W = 7;

   typedef struct packed {
      logic [VOICE_ADDR_W-1:0] addr;
      logic                    d5;
   } voice_cmd_t;

   localparam int VOICE_CMD_W = $bits(voice_cmd_t);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_LRQ = 3'd1,
      ST_SETUP    = 3'd2,
      ST_STROBE   = 3'd3,
      ST_HOLD     = 3'd4
   } wr_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/voice_cmd_fifo.sv
// Command queue for the voice bus writer: synchronous FIFO with a
// first-word-fall-through head (head_o shows the oldest entry while not empty).
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset, empties the queue
//   push_i   - write wdata_i (ignored while full)
//   wdata_i  - command to enqueue
//   pop_i    - drop the head entry (ignored while empty)
//   head_o   - oldest queued command
//   full_o   - queue holds DEPTH entries
//   empty_o  - queue holds no entries
module voice_cmd_fifo
   import voice_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  voice_cmd_t wdata_i,
   input  logic       pop_i,
   output voice_cmd_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   voice_cmd_t       mem_q [DEPTH];
   voice_cmd_t       mem_d [DEPTH];
   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q;
   logic [PTR_W:0]   rd_ptr_d;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   // Next storage and pointer values from push/pop requests.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i && !full_o) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = wdata_i;
         wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_i && !empty_o) begin
         rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Queue state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {VOICE_CMD_W{1'b0}};
         end
         wr_ptr_q <= {(PTR_W+1){1'b0}};
         rd_ptr_q <= {(PTR_W+1){1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/voice_bus_writer.sv
// Queues voice chip write commands and replays each one on the cartridge bus
// once the voice chip signals load request, with programmable setup, strobe
// and hold timing and a timeout that drops a command the chip never asks for.
// Ports:
//   clock_i, reset_i          - clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   - command handshake (ready = queue not full)
//   cmd_addr_i, cmd_d5_i      - command payload
//   lrq_n_i                   - asynchronous load request, low = chip ready
//   cart_cs_o, cart_wr_n_o    - registered bus chip-select / write strobe
//   voice_addr_o, voice_d5_o  - registered bus address / D5
//   busy_o                    - FSM active or commands pending
//   timeout_o                 - one-cycle pulse when a command is dropped
module voice_bus_writer
   import voice_bus_pkg::*;
#(
   parameter int SETUP_CYC   = 2,
   parameter int STROBE_CYC  = 3,
   parameter int HOLD_CYC    = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [VOICE_ADDR_W-1:0] cmd_addr_i,
   input  logic                    cmd_d5_i,
   input  logic                    lrq_n_i,
   output logic                    cart_cs_o,
   output logic                    cart_wr_n_o,
   output logic [VOICE_ADDR_W-1:0] voice_addr_o,
   output logic                    voice_d5_o,
   output logic                    busy_o,
   output logic                    timeout_o
);

   // One counter serves both the load-request wait and the bus phases.
   localparam int CNT_W = $clog2(max_int(max_int(SETUP_CYC, STROBE_CYC),
                                         max_int(HOLD_CYC, TIMEOUT_CYC)) + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT_CYC - 1);

   wr_state_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [1:0]              lrq_sync_q, lrq_sync_d;
   logic                    cs_q, cs_d;
   logic                    wr_n_q, wr_n_d;
   logic [VOICE_ADDR_W-1:0] addr_q, addr_d;
   logic                    d5_q, d5_d;
   logic                    timeout_q, timeout_d;

   logic                    fifo_push_s;
   logic                    fifo_pop_s;
   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   voice_cmd_t              fifo_wdata_s;
   voice_cmd_t              fifo_head_s;

   assign cmd_ready_o       = !fifo_full_s;
   assign fifo_push_s       = cmd_valid_i && !fifo_full_s;
   assign fifo_wdata_s.addr = cmd_addr_i;
   assign fifo_wdata_s.d5   = cmd_d5_i;

   voice_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock_i),
      .rst_i   (reset_i),
      .push_i  (fifo_push_s),
      .wdata_i (fifo_wdata_s),
      .pop_i   (fifo_pop_s),
      .head_o  (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   assign cart_cs_o    = cs_q;
   assign cart_wr_n_o  = wr_n_q;
   assign voice_addr_o = addr_q;
   assign voice_d5_o   = d5_q;
   assign timeout_o    = timeout_q;
   assign busy_o       = (state_q != ST_IDLE) || !fifo_empty_s;

   // Next state, phase counter, queue pop and next registered bus outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      d5_d       = d5_q;
      timeout_d  = 1'b0;
      fifo_pop_s = 1'b0;
      lrq_sync_d = {lrq_sync_q[0], lrq_n_i};
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               state_d = ST_WAIT_LRQ;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_LRQ: begin
            // A ready chip wins over an expiring wait on the same cycle.
            if (!lrq_sync_q[1]) begin
               state_d = ST_SETUP;
               cnt_d   = CNT_ZERO;
               addr_d  = fifo_head_s.addr;
               d5_d    = fifo_head_s.d5;
            end else if (cnt_q == WAIT_LAST) begin
               state_d    = ST_IDLE;
               cnt_d      = CNT_ZERO;
               fifo_pop_s = 1'b1;
               timeout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = ST_STROBE;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d    = ST_IDLE;
               cnt_d      = CNT_ZERO;
               fifo_pop_s = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
      // Bus strobes are decoded from the next state so they leave a flop.
      cs_d   = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
      wr_n_d = (state_d != ST_STROBE);
   end

   // FSM, synchronizer and bus output registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_ZERO;
         lrq_sync_q <= 2'b11;
         cs_q       <= 1'b0;
         wr_n_q     <= 1'b1;
         addr_q     <= {VOICE_ADDR_W{1'b0}};
         d5_q       <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lrq_sync_q <= lrq_sync_d;
         cs_q       <= cs_d;
         wr_n_q     <= wr_n_d;
         addr_q     <= addr_d;
         d5_q       <= d5_d;
         timeout_q  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_voice_bus_writer.sv
// Self-checking bench for voice_bus_writer: a directed table, hand-written
// corner sequences and randomized traffic, all compared against a
// transaction-level reference model kept in this file.
module tb_voice_bus_writer;

   localparam int SETUP_CYC   = 2;
   localparam int STROBE_CYC  = 3;
   localparam int HOLD_CYC    = 2;
   localparam int FIFO_DEPTH  = 4;
   localparam int TIMEOUT_CYC = 16;
   localparam int WRITE_LEN   = SETUP_CYC + STROBE_CYC + HOLD_CYC;

   logic       clock_i     = 1'b0;
   logic       reset_i     = 1'b1;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [6:0] cmd_addr_i  = 7'h00;
   logic       cmd_d5_i    = 1'b0;
   logic       lrq_n_i     = 1'b1;
   logic       cart_cs_o;
   logic       cart_wr_n_o;
   logic [6:0] voice_addr_o;
   logic       voice_d5_o;
   logic       busy_o;
   logic       timeout_o;

   always #5 clock_i = ~clock_i;

   voice_bus_writer #(
      .SETUP_CYC   (SETUP_CYC),
      .STROBE_CYC  (STROBE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_d5_i     (cmd_d5_i),
      .lrq_n_i      (lrq_n_i),
      .cart_cs_o    (cart_cs_o),
      .cart_wr_n_o  (cart_wr_n_o),
      .voice_addr_o (voice_addr_o),
      .voice_d5_o   (voice_d5_o),
      .busy_o       (busy_o),
      .timeout_o    (timeout_o)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [6:0] addr;
      logic       d5;
   } tcmd_t;

   tcmd_t      m_q[$];
   int         m_mode;       // 0 = idle, 1 = waiting for chip, 2 = bus write running
   int         m_age;        // cycles already spent in the current mode
   logic       m_lrq1, m_lrq2;
   logic [6:0] m_addr;
   logic       m_d5;
   logic       m_tmo;

   task automatic model_edge(input logic rst, input logic valid, input logic [6:0] a,
                             input logic d5, input logic lrq);
      logic ready_pre;
      logic lrq_seen;
      if (rst) begin
         m_q.delete();
         m_mode = 0; m_age = 0;
         m_lrq1 = 1'b1; m_lrq2 = 1'b1;
         m_addr = 7'h00; m_d5 = 1'b0; m_tmo = 1'b0;
      end else begin
         ready_pre = (m_q.size() < FIFO_DEPTH);
         lrq_seen  = m_lrq2;
         m_tmo     = 1'b0;
         if (m_mode == 0) begin
            if (m_q.size() > 0) begin m_mode = 1; m_age = 0; end
         end else if (m_mode == 1) begin
            if (!lrq_seen) begin
               m_mode = 2; m_age = 0;
               m_addr = m_q[0].addr; m_d5 = m_q[0].d5;
            end else if (m_age == TIMEOUT_CYC - 1) begin
               m_q.delete(0); m_tmo = 1'b1; m_mode = 0; m_age = 0;
            end else begin
               m_age++;
            end
         end else begin
            if (m_age == WRITE_LEN - 1) begin
               m_q.delete(0); m_mode = 0; m_age = 0;
            end else begin
               m_age++;
            end
         end
         if (valid && ready_pre) m_q.push_back(tcmd_t'({a, d5}));
         m_lrq2 = m_lrq1;
         m_lrq1 = lrq;
      end
   endtask

   function automatic logic [31:0] model_vec();
      logic cs, wr_n, rdy, bsy;
      cs   = (m_mode == 2);
      wr_n = !(cs && m_age >= SETUP_CYC && m_age < SETUP_CYC + STROBE_CYC);
      rdy  = (m_q.size() < FIFO_DEPTH);
      bsy  = (m_mode != 0) || (m_q.size() > 0);
      return 32'({cs, wr_n, m_addr, m_d5, rdy, bsy, m_tmo});
   endfunction

   function automatic logic [31:0] dut_vec();
      return 32'({cart_cs_o, cart_wr_n_o, voice_addr_o, voice_d5_o, cmd_ready_o, busy_o, timeout_o});
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- bus write log ----------------
   logic       prev_cs;
   int         low_run;
   int         n_writes;
   logic [6:0] got_addr[$];
   int         got_gap[$];

   task automatic clear_log();
      got_addr.delete(); got_gap.delete();
      n_writes = 0; low_run = 0; prev_cs = cart_cs_o;
   endtask

   task automatic log_bus();
      if (cart_cs_o && !prev_cs) begin
         got_addr.push_back(voice_addr_o);
         if (n_writes > 0) got_gap.push_back(low_run);
         n_writes++;
         low_run = 0;
      end
      if (!cart_cs_o) low_run++;
      prev_cs = cart_cs_o;
   endtask

   // One clock: drive inputs, take the edge, advance model, compare all outputs.
   task automatic cycle(input logic rst, input logic valid, input logic [6:0] a,
                        input logic d5, input logic lrq);
      reset_i = rst; cmd_valid_i = valid; cmd_addr_i = a; cmd_d5_i = d5; lrq_n_i = lrq;
      @(posedge clock_i);
      model_edge(rst, valid, a, d5, lrq);
      #1;
      check("bus_vs_model", dut_vec(), model_vec());
      log_bus();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic       rst, valid;
      logic [6:0] addr;
      logic       d5, lrq;
      logic       e_cs, e_wr_n;
      logic [6:0] e_addr;
      logic       e_d5, e_ready, e_busy, e_tmo;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic       lrq_lvl;
      logic       found;
      int         first_k;
      int         pulses;
      int         cs_seen;
      logic [6:0] exp_addr[$];

      // Single write with the chip permanently ready: cs rises two edges
      // after the push, strobe low for cs cycles 3..5, cs high for 7 cycles.
      //         rst   vld   addr   d5    lrq  | cs    wr_n  vaddr  vd5   rdy   busy  tmo
      tbl[0]  = '{1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 7'h2A, 1'b1, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h2A, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h2A, 1'b1, 1'b1, 1'b0, 1'b0};

      model_edge(1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b1);

      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].rst, tbl[i].valid, tbl[i].addr, tbl[i].d5, tbl[i].lrq);
         check($sformatf("table_row%0d", i), dut_vec(),
               32'({tbl[i].e_cs, tbl[i].e_wr_n, tbl[i].e_addr, tbl[i].e_d5,
                    tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_tmo}));
      end

      // Queue fill with the chip not ready: 4 accepted, 5th refused, then 4 ordered writes.
      cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
      clear_log();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 7'(7'h10 + i), i[0], 1'b1);
         check($sformatf("ready_after_push%0d", i), 32'(cmd_ready_o), (i < 3) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b1);
      check("no_write_before_lrq", 32'(n_writes), 32'd0);
      for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
      check("fill_write_count", 32'(got_addr.size()), 32'd4);
      for (int i = 0; i < got_addr.size() && i < 4; i++)
         check($sformatf("fill_order%0d", i), 32'(got_addr[i]), 32'(7'h10 + i));
      for (int i = 0; i < got_gap.size(); i++)
         check($sformatf("fill_gap%0d", i), 32'(got_gap[i]), 32'd2);

      // Timeout: one command, chip never ready.
      cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 7'h55, 1'b1, 1'b1);
      first_k = -1; pulses = 0; cs_seen = 0;
      for (int k = 1; k <= 30; k++) begin
         cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b1);
         if (timeout_o) begin
            pulses++;
            if (first_k < 0) first_k = k;
         end
         if (cart_cs_o) cs_seen++;
      end
      check("timeout_edge", 32'(first_k), 32'd17);
      check("timeout_pulses", 32'(pulses), 32'd1);
      check("timeout_no_cs", 32'(cs_seen), 32'd0);
      check("timeout_busy_clear", 32'(busy_o), 32'd0);

      // Reset in the middle of the strobe phase with a second command queued.
      cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 7'h33, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 7'h44, 1'b1, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
         if (!cart_wr_n_o) found = 1'b1;
      end
      check("strobe_reached", 32'(found), 32'd1);
      cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
      check("rst_mid_strobe", 32'({cart_cs_o, cart_wr_n_o, busy_o, cmd_ready_o}), 32'b0101);
      cs_seen = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
         if (cart_cs_o) cs_seen++;
      end
      check("rst_queue_emptied", 32'(cs_seen), 32'd0);

      // One-cycle load-request glitch while waiting: write starts two edges later.
      cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 7'h21, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
      first_k = -1;
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b1);
         if (cart_cs_o && first_k < 0) first_k = k;
      end
      check("glitch_start", 32'(first_k), 32'd2);

      // Three queued commands with the chip ready: 2 cs-low cycles between writes.
      cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
      clear_log();
      exp_addr = '{7'h01, 7'h02, 7'h03};
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, exp_addr[i], 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
      check("three_write_count", 32'(got_addr.size()), 32'd3);
      for (int i = 0; i < got_addr.size() && i < 3; i++)
         check($sformatf("three_order%0d", i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check("three_gap_count", 32'(got_gap.size()), 32'd2);
      for (int i = 0; i < got_gap.size(); i++)
         check($sformatf("three_gap%0d", i), 32'(got_gap[i]), 32'd2);

      // Randomized traffic with long ready/not-ready runs, glitches and rare resets.
      lrq_lvl = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 29) == 0) lrq_lvl = ~lrq_lvl;
         cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
               7'($urandom_range(0, 127)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 24) == 0) ? ~lrq_lvl : lrq_lvl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
